instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Producer end of the decode stage's Instruction interface: owns the fetch PC, requests words from instruction memory over a variable-latency req/ack handshake, and buffers them in a small prefetch queue.
- Drives the IF/ID pipeline register: Instruction, PCPlus4, InstrValid.
- Honours Stall from the hazard unit and PC redirects for taken branches, jumps and jr, as resolved by the top level.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- QDEPTH, 2, prefetch queue entries (power of two, ≥2).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Stall  in  1  hold the IF/ID outputs and stop popping the queue.
- RedirectValid  in  1  change the fetch PC this cycle.
- RedirectAddr  in  32  new fetch PC (word-aligned; bits [1:0] ignored).
- imem_req  out  1  memory request, combinational from state.
- imem_addr  out  32  request address; stable while imem_req is high.
- imem_ack  in  1  transfer completes in any cycle with imem_req && imem_ack.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- Instruction  out  32  IF/ID instruction to the decode stage.
- PCPlus4  out  32  IF/ID PC+4 of that instruction.
- InstrValid  out  1  IF/ID entry holds a real instruction.

Behaviour:
- Reset (asynchronous):
  - fetch_pc = RESET_PC; queue empty (count = 0); state = FETCH.
  - Instruction = 32'h0 (NOP); PCPlus4 = 0; InstrValid = 0.
  - A request outstanding at reset is abandoned; instruction memory is reset together with this block.
- Fetch FSM, states FETCH and DISCARD:
  - FETCH: imem_req = (count < QDEPTH); imem_addr = fetch_pc.
    - On a completed transfer without redirect: push {fetch_pc+4, imem_rdata} into the queue; fetch_pc += 4.
  - DISCARD: imem_req = 1; imem_addr = held abandoned address (discard_addr).
    - On imem_ack: drop the data; go to FETCH.
  - Address is never changed while a request is pending without ack; the handshake is never broken.
- Redirect, highest priority, sampled at the clock edge:
  - fetch_pc <= {RedirectAddr[31:2], 2'b00}; queue flushed.
  - IF/ID: InstrValid <= 0, Instruction <= 0; PCPlus4 holds.
  - Redirect overrides Stall.
  - If imem_req is high and imem_ack is low that cycle: discard_addr <= imem_addr; state <= DISCARD.
  - If ack arrives in the redirect cycle: data dropped; state stays FETCH.
  - Redirect while in DISCARD: update fetch_pc only; stay in DISCARD.
- IF/ID update when !Stall and no redirect:
  - Queue non-empty: pop head into Instruction/PCPlus4; InstrValid <= 1.
  - Queue empty: InstrValid <= 0, Instruction <= 0.
- Stall without redirect:
  - IF/ID outputs hold; no pop.
  - Fetch continues until the queue is full.
- Simultaneous push and pop in one cycle is legal; count is unchanged.
- Latency with zero-wait memory (ack in the request cycle):
  - Redirect at edge N → target instruction on Instruction with InstrValid = 1 after edge N+2.
  - Steady state: one instruction per cycle.
- Width rules:
  - All PC arithmetic is modulo 2^32; fetch_pc wraps from 32'hFFFF_FFFC to 0.
  - Queue pointers wrap modulo QDEPTH; count is log2(QDEPTH)+1 bits wide.

Decomposition:
- Shared package (fetch_defs):
  - NOP_INSTR = 32'h0000_0000.
  - Default RESET_PC.
  - FSM state encoding: FETCH = 1'b0, DISCARD = 1'b1.
- One sub-module, prefetch_queue:
  - Synchronous FIFO of 64-bit entries {pc4, instr}.
  - Ports: push, pop, flush, full, empty, count, head data.
  - Asynchronous reset.

Test Plan:
- Reset → release, zero-wait ack always high: imem_addr sequence 0x0, 0x4, 0x8. Instruction/PCPlus4 = (mem[0], 0x4) after edge 2, (mem[1], 0x8) after edge 3; InstrValid stays 1 from then on.
- Stall asserted for 3 cycles in steady state: outputs frozen; queue reaches count = 2; imem_req drops to 0. On release, the next two outputs come from the queue with no gap, and the PCPlus4 sequence is continuous.
- 3-cycle memory latency, redirect to 0x100 in the first wait cycle of a request to 0x10: imem_addr stays 0x10 until ack, and that data never appears on the outputs. Next request is 0x100; first valid output is (mem[0x100], 0x104).
- Redirect and Stall in the same cycle: InstrValid = 0 and Instruction = 0 after that edge. The target instruction appears once Stall is released.
- Redirect to 0xFFFF_FFFC: outputs (mem[0xFFFF_FFFC], PCPlus4 = 0x0); the next imem_addr is 0x0.
- Reset asserted mid-request with ack pending: outputs clear immediately, without a clock edge. After release, imem_addr = RESET_PC and the queue is empty.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared constants, FSM encoding and entry layout for the fetch stage
package fetch_defs;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction memory req/ack handshake
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instruction_fetch_prefetch_queue.sv
// rtl/instruction_fetch_prefetch_queue.sv - synchronous FIFO of {pc4, instr} entries
module prefetch_queue
  import fetch_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch PC, imem req/ack FSM, prefetch queue and IF/ID register
module instruction_fetch
  import fetch_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Stall,
  input  logic                       RedirectValid,
  input  logic [31:0]                RedirectAddr,
  instruction_fetch_if.master        imem,
  output logic [31:0]                Instruction,
  output logic [31:0]                PCPlus4,
  output logic                       InstrValid
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  discard_addr_q, discard_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;

  logic             q_push, q_pop, q_flush, q_full, q_empty;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_head, q_push_data;
  logic             xfer;

  // A pending request keeps its address: DISCARD replays the abandoned one until it is acked.
  assign imem.imem_req  = (state_q == DISCARD) || (q_count < QDEPTH_C);
  assign imem.imem_addr = (state_q == DISCARD) ? discard_addr_q : fetch_pc_q;
  assign xfer           = imem.imem_req && imem.imem_ack;
  assign q_push_data    = '{pc4: fetch_pc_q + 32'd4, instr: imem.imem_rdata};

  assign Instruction = instr_q;
  assign PCPlus4     = pc4_q;
  assign InstrValid  = valid_q;

  prefetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (Clk),
    .rst       (Reset),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (q_flush),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head_data (q_head)
  );

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    discard_addr_d = discard_addr_q;
    instr_d        = instr_q;
    pc4_d          = pc4_q;
    valid_d        = valid_q;
    q_push         = 1'b0;
    q_pop          = 1'b0;
    q_flush        = 1'b0;

    if (state_q == DISCARD && imem.imem_ack) state_d = FETCH;

    if (RedirectValid) begin
      fetch_pc_d = word_align(RedirectAddr);
      q_flush    = 1'b1;
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      if (state_q == FETCH && imem.imem_req && !imem.imem_ack) begin
        discard_addr_d = imem.imem_addr;
        state_d        = DISCARD;
      end
    end else begin
      if (state_q == FETCH && xfer && !q_full) begin
        q_push     = 1'b1;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (!Stall) begin
        if (!q_empty) begin
          q_pop   = 1'b1;
          instr_d = q_head.instr;
          pc4_d   = q_head.pc4;
          valid_d = 1'b1;
        end else begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= FETCH;
      fetch_pc_q     <= RESET_PC;
      discard_addr_q <= '0;
      instr_q        <= NOP_INSTR;
      pc4_q          <= '0;
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      discard_addr_q <= discard_addr_d;
      instr_q        <= instr_d;
      pc4_q          <= pc4_d;
      valid_q        <= valid_d;
    end
  end

endmodule
